step_run_controller: RTL
========================

Name: step_run_controller

Overview:
- Sequences the processor's slow clock domain with a single-cycle clock-enable instead of a derived clock.
- Supports three modes: free-run at a programmable divide ratio, debounced single-step from a push button, and halt on core request.
- Sits between the board inputs (switch, button) and the pipeline's register enables.
- Also drives a `phase` bit so dual-phase memory sharing keeps working without a generated clock.

Parameters:
- CNT_W, 24, width of divide counter and div_sel.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a new step_btn level.
- EN_CNT_W, 16, width of en_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- run_sw  input  1  raw run switch; asynchronous to clk.
- step_btn  input  1  raw push button; bouncy, asynchronous.
- halt_req  input  1  core halt request (e.g. ecall/ebreak retire); synchronous to clk.
- div_sel  input  CNT_W  divide ratio; 0 treated as 1.
- clk_en  output  1  one-cycle enable pulse for pipeline registers.
- phase  output  1  toggles on every clk_en pulse.
- state  output  2  00 IDLE, 01 RUN, 10 HALTED.
- en_count  output  EN_CNT_W  number of clk_en pulses issued; wraps.

Behaviour:
- Reset (rst=0): asynchronous, all flops cleared immediately.
  - clk_en=0, phase=0, state=IDLE, en_count=0, div_cnt=0, debounce state=0.
  - div_q = max(div_sel, 1) is captured on the first edge after release.
  - Reset mid-pulse drops clk_en at once.
- Synchronisers: run_sw and step_btn each pass through 2 flops (run_s, btn_s). run_sw is not debounced.
- Debounce counter:
  - Clears whenever btn_s equals btn_db or differs from its previous value.
  - Otherwise counts while btn_s differs from btn_db; at DEBOUNCE_CYCLES, btn_db <= btn_s.
- step_pulse = btn_db rising edge, exactly one cycle per accepted press. Falling edges produce nothing.
- clk_en is a flop: high for exactly the one cycle following the edge at which an issue condition was true. It is never high two cycles in a row except when div_q=1 in RUN.
- FSM, evaluated each edge, with priority in listed order:
  - IDLE:
    - halt_req=1 -> HALTED.
    - run_s=1 -> RUN, div_cnt=0, div_q reloaded.
    - step_pulse=1 -> issue one clk_en, stay IDLE.
  - RUN:
    - halt_req=1 -> HALTED, no issue this edge even if the count is terminal.
    - run_s=0 -> IDLE, no issue, div_cnt=0.
    - div_cnt==div_q-1 -> issue, div_cnt=0, div_q <= max(div_sel,1). The new ratio takes effect only at wrap.
    - else div_cnt+1.
    - step_pulse is ignored in RUN.
  - HALTED:
    - No issue; step_pulse ignored.
    - run_s=0 -> IDLE. halt_req level is irrelevant once HALTED.
    - Leaving HALTED requires run_sw off; run_sw on then gives RUN.
  - Encoding 11 is unreachable; if entered, next state is IDLE.
- Each issued pulse:
  - phase toggles on the same edge clk_en rises.
  - en_count increments on the same edge. 2^EN_CNT_W-1 -> 0 wrap.
- Latency:
  - run_sw change -> state change on the 3rd clk edge.
  - RUN entry -> first clk_en high after div_q cycles.
  - Clean button press -> clk_en 2+DEBOUNCE_CYCLES+1 edges after btn change.
- div_sel change mid-RUN never shortens or lengthens the current period.

Test Plan:
- Reset, div_sel=4, run_sw=1 for 43 cycles -> state=01 from edge 3; clk_en period exactly 4 cycles; after 10 pulses en_count=10, phase=0.
- div_sel=0 then div_sel=1 in RUN -> clk_en high every cycle; phase alternates each cycle; en_count increments every cycle.
- div_sel changed 4->7 when div_cnt=1 -> current period stays 4; next period 7.
- run_sw=0; step_btn bounce with pulses of 3,5,2 cycles (each <16) -> no clk_en. Then held high 40 cycles -> exactly one clk_en, 19 edges after the stable rise; en_count +1. Release and bounce -> no pulse.
- RUN with div_sel=3; halt_req=1 on the terminal-count cycle -> no clk_en; state=10; en_count frozen. step_btn press -> nothing. run_sw=0 -> state=00; run_sw=1 -> RUN.
- rst=0 asserted mid-RUN while clk_en=1 -> clk_en, phase, en_count, state drop to 0 before the next edge. Release -> IDLE until run_s=1 (3 edges).

Source files
------------

// File: rtl/step_run_controller.sv
// rtl/step_run_controller.sv - clock-enable sequencer for the slow processor domain (free-run / single-step / halt)
//
// Purpose: produces a single-cycle clock enable for the pipeline registers instead of a
// derived clock. Free-runs at a programmable divide ratio while the run switch is on,
// issues one enable per debounced button press while idle, and stops on a core halt request.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   run_sw    in   raw run switch (asynchronous, synchronised, not debounced)
//   step_btn  in   raw push button (asynchronous, bouncy; synchronised and debounced)
//   halt_req  in   core halt request, synchronous to clk
//   div_sel   in   free-run divide ratio, 0 behaves as 1
//   clk_en    out  one-cycle enable pulse for pipeline registers
//   phase     out  toggles with every clk_en pulse
//   state     out  00 IDLE, 01 RUN, 10 HALTED
//   en_count  out  number of clk_en pulses issued, wrapping
module step_run_controller #(
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EN_CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_sw,
    input  logic                step_btn,
    input  logic                halt_req,
    input  logic [CNT_W-1:0]    div_sel,
    output logic                clk_en,
    output logic                phase,
    output logic [1:0]          state,
    output logic [EN_CNT_W-1:0] en_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_run_meta;
    logic                r_run_s;
    logic                r_btn_meta;
    logic                r_btn_s;
    logic                r_btn_prev;
    logic                r_btn_db;
    logic                r_btn_db_d;
    logic [DB_W-1:0]     r_db_cnt;

    logic [CNT_W-1:0]    r_div_cnt;
    logic [CNT_W-1:0]    r_div_q;
    logic                r_clk_en;
    logic                r_phase;
    logic [EN_CNT_W-1:0] r_en_count;

    logic                w_step_pulse;
    logic                w_issue;
    logic [CNT_W-1:0]    w_div_eff;
    logic [CNT_W-1:0]    w_div_cnt_next;
    logic [CNT_W-1:0]    w_div_q_next;

    assign w_div_eff    = (div_sel == '0) ? CNT_W'(1) : div_sel;
    assign w_step_pulse = r_btn_db & ~r_btn_db_d;

    // Next-state and issue decision; priority is halt, then run switch, then count/step.
    always_comb begin
        w_next_state   = r_state;
        w_issue        = 1'b0;
        w_div_cnt_next = r_div_cnt;
        w_div_q_next   = r_div_q;
        case (r_state)
            ST_IDLE: begin
                // Ratio is tracked continuously while idle so RUN entry starts with a fresh value.
                w_div_cnt_next = '0;
                w_div_q_next   = w_div_eff;
                if (halt_req) begin
                    w_next_state = ST_HALTED;
                end else if (r_run_s) begin
                    w_next_state = ST_RUN;
                end else if (w_step_pulse) begin
                    w_issue = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_next_state = ST_HALTED;
                end else if (!r_run_s) begin
                    w_next_state   = ST_IDLE;
                    w_div_cnt_next = '0;
                end else if (r_div_cnt == r_div_q - CNT_W'(1)) begin
                    // New ratio only latched at wrap so the running period is never disturbed.
                    w_issue        = 1'b1;
                    w_div_cnt_next = '0;
                    w_div_q_next   = w_div_eff;
                end else begin
                    w_div_cnt_next = r_div_cnt + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                if (!r_run_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_btn_prev <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_db_cnt   <= '0;
            r_div_cnt  <= '0;
            r_div_q    <= '0;
            r_clk_en   <= 1'b0;
            r_phase    <= 1'b0;
            r_en_count <= '0;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
            r_btn_meta <= step_btn;
            r_btn_s    <= r_btn_meta;
            r_btn_prev <= r_btn_s;
            r_btn_db_d <= r_btn_db;

            // The first cycle of a new level is spent clearing (btn_s != prev), so reaching
            // DEBOUNCE_CYCLES-2 here means the level has been held DEBOUNCE_CYCLES cycles.
            if ((r_btn_s == r_btn_db) || (r_btn_s != r_btn_prev)) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 2)) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            r_div_cnt <= w_div_cnt_next;
            r_div_q   <= w_div_q_next;
            r_clk_en  <= w_issue;
            if (w_issue) begin
                r_phase    <= ~r_phase;
                r_en_count <= r_en_count + EN_CNT_W'(1);
            end
        end
    end

    assign clk_en   = r_clk_en;
    assign phase    = r_phase;
    assign state    = r_state;
    assign en_count = r_en_count;

endmodule
